// File: rtl/commit_mem_responder_pkg.sv
// Shared definitions for the ROB commit-port memory responder: bus widths,
// default IO address, boolean constants and the responder state encoding.
package commit_mem_responder_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] IO_ADDR_DEFAULT = 32'h0003_0000;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ST_GNT,
        ST_BYTE,
        ST_DONE,
        IO_GNT,
        IO_WAIT,
        IO_DONE
    } state_t;

    // Stores landing in the top 64 KiB window go to the IO sink, not RAM.
    function automatic logic is_io_addr(input logic [ADDR_WIDTH-1:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/commit_mem_responder_if.sv
// Signal bundle between the ROB/arbiter side and the commit memory responder.
// The responder uses the slave view; the ROB/arbiter/RAM side uses master.
interface commit_mem_responder_if;
    import commit_mem_responder_pkg::*;

    logic                  rdy;
    logic                  clear;
    logic                  if_out_mem;
    logic [5:0]            out_mem_size;
    logic [ADDR_WIDTH-1:0] out_mem_addr;
    logic [DATA_WIDTH-1:0] out_mem_data;
    logic                  if_stored;
    logic                  if_out_mem_io;
    logic                  if_get_mem;
    logic [DATA_WIDTH-1:0] data_mem;
    logic                  port_req;
    logic                  port_gnt;
    logic [7:0]            mem_din;
    logic [7:0]            mem_dout;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic                  mem_wr;
    logic                  io_buffer_full;

    modport slave (
        input  rdy, clear, if_out_mem, out_mem_size, out_mem_addr, out_mem_data,
               if_out_mem_io, port_gnt, mem_din, io_buffer_full,
        output if_stored, if_get_mem, data_mem, port_req, mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, clear, if_out_mem, out_mem_size, out_mem_addr, out_mem_data,
               if_out_mem_io, port_gnt, mem_din, io_buffer_full,
        input  if_stored, if_get_mem, data_mem, port_req, mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/commit_mem_responder_mem_byte_serializer.sv
// Holds a committed store word and walks it out one little-endian byte at a
// time; cnt always names the next byte still to be issued.
module commit_mem_responder_mem_byte_serializer
    import commit_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  load,
    input  logic                  advance,
    input  logic [5:0]            size_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [7:0]            lane,
    output logic [ADDR_WIDTH-1:0] lane_addr,
    output logic                  done,
    output logic                  is_io
);

    logic [DATA_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] base;
    logic [5:0]            size;
    logic [2:0]            cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            base <= '0;
            size <= '0;
            cnt  <= '0;
        end else if (rdy) begin
            if (load) begin
                word <= data_in;
                base <= addr_in;
                size <= size_in;
                cnt  <= '0;
            end else if (advance) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign lane      = word[{cnt[1:0], 3'b000} +: 8];
    assign lane_addr = base + {{(ADDR_WIDTH-3){1'b0}}, cnt};
    assign done      = ({3'b000, cnt} == size);
    assign is_io     = is_io_addr(base);

endmodule

// File: rtl/commit_mem_responder.sv
// Commit-port memory responder: serialises committed stores and head-of-ROB IO
// loads onto the shared byte-wide RAM bus. Define COMMIT_MEM_IO_STALL_EN to let
// io_buffer_full hold back bytes of IO stores.
module commit_mem_responder
    import commit_mem_responder_pkg::*;
#(
    parameter int                    READ_LAT = 2,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR  = IO_ADDR_DEFAULT
)(
    input  logic                  clk,
    input  logic                  rst,
    commit_mem_responder_if.slave bus
);

    localparam logic [3:0] READ_LAT_W = 4'(READ_LAT);

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic                  stall;
    logic                  store_issue;
    logic                  read_capture;
    logic                  clear_hit;
    logic                  port_req;
    logic                  if_stored;
    logic                  if_get_mem;
    logic                  mem_wr_q;
    logic [ADDR_WIDTH-1:0] mem_a_q;
    logic [7:0]            mem_dout_q;
    logic [DATA_WIDTH-1:0] data_mem_q;
    logic [7:0]            ser_lane;
    logic [ADDR_WIDTH-1:0] ser_lane_addr;
    logic                  ser_done;
    logic                  ser_is_io;

    commit_mem_responder_mem_byte_serializer u_serializer (
        .clk       (clk),
        .rst       (rst),
        .rdy       (bus.rdy),
        .load      (state == IDLE && bus.if_out_mem),
        .advance   (store_issue),
        .size_in   (bus.out_mem_size),
        .addr_in   (bus.out_mem_addr),
        .data_in   (bus.out_mem_data),
        .lane      (ser_lane),
        .lane_addr (ser_lane_addr),
        .done      (ser_done),
        .is_io     (ser_is_io)
    );

`ifdef COMMIT_MEM_IO_STALL_EN
    assign stall = ser_is_io && bus.io_buffer_full;
`else
    logic unused_io_stall;
    assign unused_io_stall = ^{ser_is_io, bus.io_buffer_full};
    assign stall = FALSE;
`endif

    // A committed store is never abandoned, so clear only acts outside ST_*.
    assign clear_hit = bus.clear
                     && (state inside {IDLE, IO_GNT, IO_WAIT, IO_DONE})
                     && !(state == IDLE && bus.if_out_mem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (bus.rdy) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.if_out_mem)         state_next = ST_GNT;
                else if (bus.clear)         state_next = IDLE;
                else if (bus.if_out_mem_io) state_next = IO_GNT;
            end
            ST_GNT:  if (bus.port_gnt) state_next = ST_BYTE;
            ST_BYTE: if (ser_done)     state_next = ST_DONE;
            ST_DONE: state_next = IDLE;
            IO_GNT: begin
                if (bus.clear)         state_next = IDLE;
                else if (bus.port_gnt) state_next = IO_WAIT;
            end
            IO_WAIT: begin
                if (bus.clear)                   state_next = IDLE;
                else if (wait_cnt == READ_LAT_W) state_next = IO_DONE;
            end
            IO_DONE: if (bus.clear || bus.if_out_mem_io) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus request is held from grant request until the done state.
    always_comb begin
        port_req     = FALSE;
        if_stored    = FALSE;
        if_get_mem   = FALSE;
        store_issue  = FALSE;
        read_capture = FALSE;
        unique case (state)
            ST_GNT: begin
                port_req    = TRUE;
                store_issue = bus.port_gnt && !stall;
            end
            ST_BYTE: begin
                port_req    = TRUE;
                store_issue = !ser_done && !stall;
            end
            ST_DONE: if_stored = TRUE;
            IO_GNT:  port_req = TRUE;
            IO_WAIT: begin
                port_req     = TRUE;
                read_capture = !bus.clear && (wait_cnt == READ_LAT_W);
            end
            IO_DONE: if_get_mem = TRUE;
            default: port_req = FALSE;
        endcase
    end

    // Bus outputs are registered so a byte is on the bus exactly while in ST_BYTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wr_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            data_mem_q <= '0;
            wait_cnt   <= '0;
        end else if (bus.rdy) begin
            mem_wr_q <= store_issue;
            wait_cnt <= (state == IO_WAIT) ? wait_cnt + 4'd1 : 4'd0;
            if (store_issue) begin
                mem_a_q    <= ser_lane_addr;
                mem_dout_q <= ser_lane;
            end else if (clear_hit) begin
                mem_a_q    <= '0;
                mem_dout_q <= '0;
            end else if (state == IO_GNT && bus.port_gnt) begin
                mem_a_q <= IO_ADDR;
            end
            if (clear_hit) begin
                data_mem_q <= '0;
            end else if (read_capture) begin
                data_mem_q <= {24'b0, bus.mem_din};
            end
        end
    end

    assign bus.port_req   = port_req;
    assign bus.if_stored  = if_stored;
    assign bus.if_get_mem = if_get_mem;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.data_mem   = data_mem_q;

endmodule
